// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant plus encoded select, with a one-cycle
// dead gap between owners and an optional hold timeout that forces a preempt.
module bus_grant_arbiter #(
  parameter int unsigned N_REQ    = 24,
  parameter int unsigned MAX_HOLD = 8,
  parameter logic [4:0]  IDLE_SEL = 5'd31
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  input  logic        release_bus,
  output logic [31:0] grant,
  output logic [4:0]  sel,
  output logic        busy,
  output logic        preempt
);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  localparam logic [31:0] ReqMask  = (32'h1 << N_REQ) - 32'h1;
  localparam logic [4:0]  LastIdx  = 5'(N_REQ - 1);
  localparam logic [15:0] HoldLast = 16'(MAX_HOLD - 1);

  state_e      state_q, state_d;
  logic [31:0] grant_q, grant_d;
  logic [4:0]  sel_q, sel_d;
  logic        preempt_q, preempt_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [15:0] hold_q, hold_d;

  // Rotating priority search starting at ptr_q
  logic [31:0] req_m;
  logic        win_found;
  logic [4:0]  win_idx;
  logic [5:0]  idx;

  always_comb begin
    req_m     = req & ReqMask;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + 6'(i);
      if (idx >= 6'(N_REQ)) begin
        idx = idx - 6'(N_REQ);
      end
      if (!win_found && req_m[idx[4:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[4:0];
      end
    end
  end

  logic withdraw, timeout, own_exit;
  logic [4:0] ptr_next;

  always_comb begin
    withdraw = ~req[sel_q];
    timeout  = (MAX_HOLD != 0) && (hold_q == HoldLast);
    own_exit = release_bus || withdraw || timeout;
    ptr_next = (sel_q == LastIdx) ? 5'd0 : sel_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      sel_q     <= IDLE_SEL;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          state_d = StOwn;
          grant_d = 32'h1 << win_idx;
          sel_d   = win_idx;
          hold_d  = '0;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          sel_d   = IDLE_SEL;
        end
      end
      StOwn: begin
        if (own_exit) begin
          state_d   = StGap;
          grant_d   = '0;
          sel_d     = IDLE_SEL;
          ptr_d     = ptr_next;
          hold_d    = '0;
          // Preempt flags only a pure timeout; a voluntary exit on the same edge wins
          preempt_d = timeout && !release_bus && !withdraw;
        end else if (hold_q != 16'hFFFF) begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        sel_d   = IDLE_SEL;
      end
    endcase
  end

  always_comb begin
    grant   = grant_q;
    sel     = sel_q;
    busy    = (state_q == StOwn);
    preempt = preempt_q;
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (clr) $onehot0(grant_q));
  a_sel_idle: assert property (@(posedge clk) disable iff (clr)
      (grant_q == '0) |-> (sel_q == IDLE_SEL));
  a_sel_match: assert property (@(posedge clk) disable iff (clr)
      (grant_q != '0) |-> (grant_q == (32'h1 << sel_q)));

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Scoreboard bench for bus_grant_arbiter: a transaction-level owner/ptr model predicts the
// outputs after each edge; a monitor pops and compares once per cycle.
module tb_bus_grant_arbiter;

  localparam int NReq    = 24;
  localparam int MaxHold = 8;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] req = '0;
  logic        rel = 1'b0;
  logic [31:0] grant;
  logic [4:0]  sel;
  logic        busy;
  logic        preempt;

  always #5 clk = ~clk;

  bus_grant_arbiter #(
    .N_REQ   (NReq),
    .MAX_HOLD(MaxHold),
    .IDLE_SEL(5'd31)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .release_bus(rel),
    .grant      (grant),
    .sel        (sel),
    .busy       (busy),
    .preempt    (preempt)
  );

  typedef struct {
    logic [31:0] g;
    logic [4:0]  s;
    logic        b;
    logic        p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: who owns the bus (-1 none), how many grant cycles it has had, the search start.
  int owner = -1;
  int held  = 0;
  int ptr   = 0;
  bit pre   = 0;

  task automatic model_step(input bit c, input logic [31:0] r, input bit rl);
    bit to;
    if (c) begin
      owner = -1; held = 0; ptr = 0; pre = 0;
    end else if (owner >= 0) begin
      to = (MaxHold != 0) && (held == MaxHold);
      if (rl || !r[owner] || to) begin
        pre   = to && !rl && r[owner];
        ptr   = (owner + 1) % NReq;
        owner = -1;
        held  = 0;
      end else begin
        pre  = 0;
        held = held + 1;
      end
    end else begin
      pre = 0;
      for (int i = 0; i < NReq; i++) begin
        int k;
        k = (ptr + i) % NReq;
        if (r[k]) begin
          owner = k;
          held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic drive(input bit c, input logic [31:0] r, input bit rl);
    exp_t e;
    @(negedge clk);
    clr = c;
    req = r;
    rel = rl;
    model_step(c, r, rl);
    e.g = (owner >= 0) ? (32'h1 << owner) : 32'h0;
    e.s = (owner >= 0) ? 5'(owner) : 5'd31;
    e.b = (owner >= 0);
    e.p = pre;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.g || sel !== e.s || busy !== e.b || preempt !== e.p) begin
          errors++;
          $display("FAIL outputs t=%0t got grant=%h sel=%0d busy=%b preempt=%b want grant=%h sel=%0d busy=%b preempt=%b",
                   $time, grant, sel, busy, preempt, e.g, e.s, e.b, e.p);
        end
        checks++;
        if ($countones(grant) > 1) begin
          errors++;
          $display("FAIL onehot t=%0t got grant=%h want at most one bit", $time, grant);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] r;
    // Reset with all requests high, then first grant goes to bit 0
    repeat (2) drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, 32'hFFFF_FFFF, 1'b0);
    repeat (6) drive(1'b0, 32'hFFFF_FFFF, 1'b1);

    // Single requester: grant, release, gap, re-grant, drop in gap
    drive(1'b1, 32'h0, 1'b0);
    repeat (3) drive(1'b0, 32'h20, 1'b0);
    drive(1'b0, 32'h20, 1'b1);
    repeat (3) drive(1'b0, 32'h20, 1'b0);
    drive(1'b0, 32'h20, 1'b1);
    repeat (3) drive(1'b0, 32'h0, 1'b0);

    // Two requesters alternating with release each turn
    drive(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 32'h9, i[0]);

    // Timeout rotation between bits 2 and 7
    drive(1'b1, 32'h0, 1'b0);
    repeat (40) drive(1'b0, 32'h84, 1'b0);

    // Wrap-around between bit 23 and bit 0; upper bits never grant
    drive(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 32'h0080_0001, i[0]);
    drive(1'b1, 32'h0, 1'b0);
    repeat (5) drive(1'b0, 32'hFF00_0000, 1'b0);

    // Reset in the middle of an ownership
    drive(1'b1, 32'h0, 1'b0);
    repeat (4) drive(1'b0, 32'h1000, 1'b0);
    drive(1'b1, 32'h1000, 1'b0);
    repeat (4) drive(1'b0, 32'h1001, 1'b0);

    // Random traffic: sticky sparse request vectors, occasional release and reset
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: r = $urandom & $urandom & $urandom;
          1: r = $urandom;
          2: r = 32'h1 << $urandom_range(0, 31);
          default: r = $urandom & $urandom;
        endcase
      end
      drive($urandom_range(0, 199) == 0, r, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Round-robin arbiter for the shared CPU bus. Takes per-source drive requests and issues one registered one-hot grant, used as the bus-mux "out" enables.
- Also issues the matching 5-bit encoded select. The encoding is bit k gives k; no grant gives 31.
- Sits between the control unit's request lines and the bus multiplexer.
- Enforces a one-cycle dead gap between owners and an optional hold timeout.

Parameters:
N_REQ, 24, number of requesters (1..24); bits [31:N_REQ] never granted
MAX_HOLD, 8, max consecutive OWN cycles before forced preempt; 0 = no timeout
IDLE_SEL, 31, sel value driven whenever no grant is active

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
req  in  32  request vector; bit k = source k wants the bus; bits >= N_REQ ignored
release  in  1  current owner finished; sampled only in OWN
grant  out  32  registered one-hot grant (0 when none)
sel  out  5  registered encoded grant index, IDLE_SEL when grant==0
busy  out  1  1 while in OWN
preempt  out  1  one-cycle pulse, first GAP cycle after a timeout exit

Behaviour:
- Reset: clr sampled at rising edge, overrides all other inputs, including mid-OWN. Next-cycle state:
  - state=IDLE, grant=0, sel=IDLE_SEL, busy=0, preempt=0
  - ptr=0, hold_cnt=0
- State register: IDLE, OWN, GAP.
- Arbitration function (evaluated in IDLE and GAP):
  - Search masked req (bits < N_REQ) starting at ptr, ascending, wrapping N_REQ-1 to 0.
  - The first set bit is the winner w.
- IDLE: grant=0, sel=IDLE_SEL.
  - Any masked req at edge t: OWN from edge t, grant=1<<w, sel=w, busy=1, hold_cnt=0 (1-cycle latency).
  - Otherwise stay in IDLE.
- OWN: grant/sel held stable. hold_cnt increments each cycle (saturates). Exit to GAP at the edge where any of these holds:
  - release=1, or
  - req[w]=0 (owner withdrew), or
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout; owner has had exactly MAX_HOLD grant cycles)
- On exit from OWN:
  - ptr=(w+1) mod N_REQ
  - grant=0, sel=IDLE_SEL, busy=0
  - preempt=1 only if timeout was the sole cause; release or withdraw on the same edge wins, preempt=0
- GAP: exactly one cycle with grant=0; preempt returns to 0 after this cycle.
  - Arbitrates with the updated ptr: a winner moves to OWN at the next edge; none moves to IDLE.
  - Consequence: two owners are never granted on adjacent cycles.
- A timed-out owner still requesting is re-granted only after all other requesters at or after the new ptr have been served (fairness).
- req changes during OWN do not affect grant except through req[w].
- grant always one-hot or zero. sel always equals the index of the grant bit, or IDLE_SEL; both come from the same register update.
- No combinational path from inputs to outputs.

Test Plan:
1. clr=1 for 2 cycles with req=0xFFFFFFFF:
   - grant=0, sel=31, busy=0, preempt=0 throughout.
   - First edge after clr drops: grant=0x00000001, sel=0.
2. req=0x00000020 from IDLE:
   - Next edge: grant=0x00000020, sel=5, busy=1.
   - Pulse release: one GAP cycle (grant=0, sel=31), then OWN again (req still set, ptr=6 wraps to 5).
   - Drop req in GAP: goes to IDLE.
3. After reset, req=0x00000009:
   - Grant order with release each turn: bit0 (sel 0) -> gap -> bit3 (sel 3) -> gap -> bit0.
   - No cycle ever has two grant bits set.
4. MAX_HOLD=8, req=0x00000084, no release:
   - bit2 granted for exactly 8 cycles; then GAP with preempt=1 for 1 cycle.
   - Then grant=0x00000080, sel=7.
   - After its timeout, bit2 is granted again.
5. Wrap with req=0x00800001:
   - bit0 granted first; after its release, ptr=1 and bit23 is granted (sel=23).
   - After bit23 releases, ptr=0 and bit0 is granted next.
   - req bit 24..31 alone never grants (sel stays 31).
6. clr asserted during OWN (owner 12):
   - Next edge: grant=0, sel=31, busy=0.
   - Following arbitration starts from ptr=0.
